// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Parametrised multi-read-port integer register file with an
//            optional same-cycle write-to-read bypass and a sequential clear
//            engine that zeroes the array after reset or on request.
//            Register 0 is hardwired to zero.
// Ports    :
//   clk        in   1            rising-edge clock
//   rst_n      in   1            asynchronous active-low reset
//   clr_req    in   1            single-cycle request for a full array clear
//   busy       out  1            clear sweep active (writes dropped, reads 0)
//   reg_write  in   1            write enable
//   rd         in   AW           write address
//   wd         in   XLEN         write data
//   rs         in   NREAD*AW     packed read addresses, port i = rs[i*AW +: AW]
//   rdata      out  NREAD*XLEN   packed read data, port i = rdata[i*XLEN +: XLEN]
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  output logic                  busy,
  input  logic                  reg_write,
  input  logic [AW-1:0]         rd,
  input  logic [XLEN-1:0]       wd,
  input  logic [NREAD*AW-1:0]   rs,
  output logic [NREAD*XLEN-1:0] rdata
);

  // NREGS is a power of two, so the last register index is all ones.
  localparam logic [AW-1:0] LAST_IDX  = {AW{1'b1}};
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;

  // Storage has no reset; the clear engine is what zeroes it. Entry 0 is
  // never written and never read (reads of x0 are forced to zero).
  logic [XLEN-1:0] mem [NREGS];

  logic            wr_req;
  logic            wr_en;

  // ------------------------------------------------------------------------
  // Clear FSM
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= FIRST_IDX;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d   = S_CLEAR;
          clr_idx_d = FIRST_IDX;
        end
      end
      S_CLEAR: begin
        // clr_req is deliberately ignored here: a sweep in flight is never
        // restarted or extended, so its length is always NREGS-1 cycles.
        clr_idx_d = clr_idx_q + FIRST_IDX;
        if (clr_idx_q == LAST_IDX) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d   = S_CLEAR;
        clr_idx_d = FIRST_IDX;
      end
    endcase
  end

  assign busy = (state_q == S_CLEAR);

  // ------------------------------------------------------------------------
  // Write path. A clear request in the same cycle wins over the write.
  // ------------------------------------------------------------------------
  assign wr_req = reg_write && (rd != '0) && !clr_req;
  assign wr_en  = (state_q == S_IDLE) && wr_req;

  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem[clr_idx_q] <= '0;
    end else if (wr_en) begin
      mem[rd] <= wd;
    end
  end

  // ------------------------------------------------------------------------
  // Combinational read ports
  // ------------------------------------------------------------------------
  for (genvar i = 0; i < NREAD; i++) begin : g_read
    logic [AW-1:0] rs_addr;
    logic          byp_hit;

    assign rs_addr = rs[i*AW +: AW];
    // Bypass only matters outside a sweep; busy forces zero ahead of it.
    assign byp_hit = (BYPASS != 0) && wr_req && (rd == rs_addr);

    assign rdata[i*XLEN +: XLEN] = ((rs_addr == '0) || busy) ? '0
                                 : byp_hit                   ? wd
                                 :                             mem[rs_addr];
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Directed self-checking bench for regfile_mp. Two instances share
//            the write/control inputs: a 4-read-port bypassing file and a
//            2-read-port non-bypassing file (fed from read ports 0/1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic                 clk;
  logic                 rst_n;
  logic                 clr_req;
  logic                 reg_write;
  logic [AW-1:0]        rd;
  logic [XLEN-1:0]      wd;
  logic [4*AW-1:0]      rs;
  logic [2*AW-1:0]      rs_nb;
  logic                 busy;
  logic                 busy_nb;
  logic [4*XLEN-1:0]    rdata;
  logic [2*XLEN-1:0]    rdata_nb;

  int n_cmp;
  int n_bad;

  assign rs_nb = rs[2*AW-1:0];

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(4), .BYPASS(1)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_req   (clr_req),
    .busy      (busy),
    .reg_write (reg_write),
    .rd        (rd),
    .wd        (wd),
    .rs        (rs),
    .rdata     (rdata)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(2), .BYPASS(0)) u_dut_nb (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_req   (clr_req),
    .busy      (busy_nb),
    .reg_write (reg_write),
    .rd        (rd),
    .wd        (wd),
    .rs        (rs_nb),
    .rdata     (rdata_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4*AW-1:0] pack4(input int p0, input int p1,
                                            input int p2, input int p3);
    return {AW'(p3), AW'(p2), AW'(p1), AW'(p0)};
  endfunction

  // One write: inputs are presented just after a rising edge, committed on
  // the next one, and the task returns 1 time unit after that edge.
  task automatic do_write(input int addr, input logic [XLEN-1:0] data);
    reg_write = 1'b1;
    rd        = AW'(addr);
    wd        = data;
    @(posedge clk); #1;
    reg_write = 1'b0;
  endtask

  // Counts falling edges at which busy is still high. Optionally pulses
  // clr_req when the count reaches pulse_at and toggles random writes.
  task automatic measure_busy(output int cycles, input int pulse_at,
                              input bit toggle_wr);
    cycles = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
      cycles++;
      clr_req = (cycles == pulse_at);
      if (toggle_wr) begin
        reg_write = cycles[0];
        rd        = AW'(cycles);
        wd        = 32'hDEAD_0000 | 32'(cycles);
        rs        = pack4(cycles % 32, 1, 2, 3);
      end
    end
    clr_req   = 1'b0;
    reg_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int r = 0; r < NREGS; r++) begin
      rs = pack4(r, r, 31 - r, r);
      @(negedge clk);
      n_cmp++;
      if (rdata !== '0 || rdata_nb !== '0) begin
        n_bad++;
        $display("FAIL %s x%0d: got %h / %h, need all zero", tag, r, rdata, rdata_nb);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int cyc;
    rst_n = 1'b0; clr_req = 1'b0; reg_write = 1'b0;
    rd = '0; wd = '0; rs = pack4(1, 2, 3, 4);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || busy_nb !== 1'b1 || rdata !== '0 || rdata_nb !== '0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b/%b rdata=%h/%h, need busy=1 rdata=0",
               busy, busy_nb, rdata, rdata_nb);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    measure_busy(cyc, -1, 1'b1);
    n_cmp++;
    if (cyc !== 31) begin
      n_bad++;
      $display("FAIL reset_sweep_len: got %0d cycles, need 31", cyc);
    end
    n_cmp++;
    if (busy_nb !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_busy_nb: got %b, need 0", busy_nb);
    end
    check_all_zero("reset_clear");
  endtask

  task automatic test_write_read();
    do_write(5, 32'd42);
    rs = pack4(5, 0, 5, 0);
    @(negedge clk);
    n_cmp++;
    if (rdata[31:0] !== 32'd42 || rdata[63:32] !== 32'd0) begin
      n_bad++;
      $display("FAIL wr_rd_x5: got p0=%h p1=%h, need 2a / 0", rdata[31:0], rdata[63:32]);
    end
    n_cmp++;
    if (rdata_nb !== {32'd0, 32'd42}) begin
      n_bad++;
      $display("FAIL wr_rd_x5_nb: got %h, need %h", rdata_nb, {32'd0, 32'd42});
    end
    @(posedge clk); #1;
    // Write to x0 while reading x0 in the same cycle: no bypass, no storage.
    reg_write = 1'b1; rd = '0; wd = 32'hFFFF_FFFF; rs = pack4(0, 0, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (rdata !== '0 || rdata_nb !== '0) begin
      n_bad++;
      $display("FAIL x0_write_bypass: got %h / %h, need 0", rdata, rdata_nb);
    end
    @(posedge clk); #1;
    reg_write = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rdata !== '0 || rdata_nb !== '0) begin
      n_bad++;
      $display("FAIL x0_after_write: got %h / %h, need 0", rdata, rdata_nb);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bypass();
    do_write(7, 32'h55);
    reg_write = 1'b1; rd = AW'(7); wd = 32'h1234; rs = pack4(7, 5, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (rdata[31:0] !== 32'h1234) begin
      n_bad++;
      $display("FAIL bypass_on: got %h, need 1234", rdata[31:0]);
    end
    n_cmp++;
    if (rdata_nb[31:0] !== 32'h55) begin
      n_bad++;
      $display("FAIL bypass_off_old: got %h, need 55", rdata_nb[31:0]);
    end
    n_cmp++;
    if (rdata[63:32] !== 32'd42 || rdata_nb[63:32] !== 32'd42) begin
      n_bad++;
      $display("FAIL bypass_other_port: got %h / %h, need 2a", rdata[63:32], rdata_nb[63:32]);
    end
    @(posedge clk); #1;
    reg_write = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rdata[31:0] !== 32'h1234 || rdata_nb[31:0] !== 32'h1234) begin
      n_bad++;
      $display("FAIL bypass_next_cycle: got %h / %h, need 1234", rdata[31:0], rdata_nb[31:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_multiport();
    do_write(3, 32'hA);
    do_write(9, 32'hB);
    rs = pack4(9, 3, 3, 0);
    @(negedge clk);
    n_cmp++;
    if (rdata !== {32'h0, 32'hA, 32'hA, 32'hB}) begin
      n_bad++;
      $display("FAIL multiport: got %h, need %h", rdata, {32'h0, 32'hA, 32'hA, 32'hB});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clear_req();
    int cyc;
    for (int r = 1; r < NREGS; r++) do_write(r, 32'(r));
    rs = pack4(1, 31, 2, 17);
    @(negedge clk);
    n_cmp++;
    if (rdata !== {32'd17, 32'd2, 32'd31, 32'd1}) begin
      n_bad++;
      $display("FAIL load_index: got %h, need %h", rdata, {32'd17, 32'd2, 32'd31, 32'd1});
    end
    @(posedge clk); #1;
    // Clear request together with a write: no bypass, write dropped.
    clr_req = 1'b1; reg_write = 1'b1; rd = AW'(2); wd = 32'd77; rs = pack4(2, 2, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || rdata[31:0] !== 32'd2) begin
      n_bad++;
      $display("FAIL clr_req_cycle: busy=%b p0=%h, need busy=0 p0=2", busy, rdata[31:0]);
    end
    @(posedge clk); #1;
    clr_req = 1'b0; reg_write = 1'b0;
    measure_busy(cyc, 10, 1'b0);
    n_cmp++;
    if (cyc !== 31) begin
      n_bad++;
      $display("FAIL clr_sweep_len: got %0d cycles, need 31", cyc);
    end
    check_all_zero("clr_req_clear");
  endtask

  task automatic test_reset_mid_clear();
    int cyc;
    do_write(20, 32'd5);
    do_write(31, 32'd9);
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    cyc = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (busy) cyc++;
    end
    n_cmp++;
    if (cyc !== 15) begin
      n_bad++;
      $display("FAIL mid_clear_busy: got %0d busy cycles, need 15", cyc);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b1 || busy_nb !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_clear_reset_busy: got %b/%b, need 1", busy, busy_nb);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    measure_busy(cyc, -1, 1'b0);
    n_cmp++;
    if (cyc !== 31) begin
      n_bad++;
      $display("FAIL restart_sweep_len: got %0d cycles, need 31", cyc);
    end
    check_all_zero("restart_clear");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_multiport();
    test_clear_req();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
